// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_pkg
//  Purpose  : Shared definitions for the SD command arbiter slice: the
//             arbiter state encoding, the "no response" R1 value and the SD
//             command indices used by the requesters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sd_pkg;

    // Transaction sequencer states, 3-bit encoded.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_CMD_START = 3'd2,
        ST_CMD_WAIT  = 3'd3,
        ST_RP_START  = 3'd4,
        ST_RP_WAIT   = 3'd5,
        ST_DONE      = 3'd6
    } sd_state_t;

    // R1 value reported when the card never answered.
    localparam logic [7:0] R1_NONE = 8'hFF;

    // SD command indices issued by the init sequencer and block reader.
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

endpackage
`default_nettype wire

// File: rtl/sd_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sd_rr_pick
//  Purpose  : Combinational two-way round-robin picker.
//  Ports    : req[1:0]   request levels of port 1 / port 0
//             lastOwner  port served by the previous transaction
//             locked     previous owner holds the engines for a follow-on
//             pick[1:0]  one-hot winner (2'b00 when nobody may be served)
//  Revision : 1.0  initial release
// ============================================================================
module sd_rr_pick (
    input  logic [1:0] req,
    input  logic       lastOwner,
    input  logic       locked,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (locked) begin
            // Only the locked owner may continue; the other port waits.
            pick = lastOwner ? {req[1], 1'b0} : {1'b0, req[0]};
        end else if (req == 2'b11) begin
            // Tie goes to the port that was not served last.
            pick = lastOwner ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_arbiter
//  Purpose  : Shares one SD_CMD and one SD_RP engine between two requesters.
//             Round-robin grant, then command -> response sequencing, card CS
//             control and a response timeout.
//  Ports    : clk, reset                 clock, synchronous active-high reset
//             req/index/argument/lockN   requester side (N = 0, 1)
//             grantN, done, response,    owner indication, completion pulse,
//             timeout                    R1 byte and no-response flag
//             cmd*                       SD_CMD engine handshake
//             rp*                        SD_RP engine handshake
//             CS                         card chip select, active low
//  Revision : 1.0  initial release
// ============================================================================
module sd_cmd_arbiter
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [5:0]  index0,
    input  logic [5:0]  index1,
    input  logic [31:0] argument0,
    input  logic [31:0] argument1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        grant0,
    output logic        grant1,
    output logic        done,
    output logic [7:0]  response,
    output logic        timeout,
    output logic [5:0]  cmdIndex,
    output logic [31:0] cmdArgument,
    output logic        cmdStart,
    input  logic        cmdBusy,
    input  logic        cmdFinish,
    output logic        rpStart,
    input  logic        rpBusy,
    input  logic        rpFinish,
    input  logic [7:0]  rpResponse,
    output logic        CS
);

    sd_state_t        r_state;
    logic             r_owner;
    logic             r_lastOwner;
    logic             r_locked;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_pick;
    logic             w_ownerLock;

    sd_rr_pick u_pick (
        .req       ({req1, req0}),
        .lastOwner (r_lastOwner),
        .locked    (r_locked),
        .pick      (w_pick)
    );

    assign w_ownerLock = r_owner ? lock1 : lock0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_lastOwner <= 1'b1;
            r_locked    <= 1'b0;
            r_cnt       <= '0;
            CS          <= 1'b1;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            response    <= R1_NONE;
            cmdStart    <= 1'b0;
            rpStart     <= 1'b0;
            cmdIndex    <= '0;
            cmdArgument <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A locked owner with req low keeps grant and CS here.
                    if (w_pick != 2'b00) begin
                        r_owner     <= w_pick[1];
                        grant0      <= w_pick[0];
                        grant1      <= w_pick[1];
                        CS          <= 1'b0;
                        cmdIndex    <= w_pick[1] ? index1 : index0;
                        cmdArgument <= w_pick[1] ? argument1 : argument0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!cmdBusy) begin
                        r_state <= ST_CMD_START;
                    end
                end
                ST_CMD_START: begin
                    cmdStart <= 1'b1;
                    r_state  <= ST_CMD_WAIT;
                end
                ST_CMD_WAIT: begin
                    if (cmdFinish) begin
                        cmdStart <= 1'b0;
                        r_state  <= ST_RP_START;
                    end
                end
                ST_RP_START: begin
                    if (!rpBusy) begin
                        rpStart <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_RP_WAIT;
                    end
                end
                ST_RP_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (rpFinish) begin
                        response <= rpResponse;
                        timeout  <= 1'b0;
                        rpStart  <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        response <= R1_NONE;
                        timeout  <= 1'b1;
                        rpStart  <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // done is visible during this state and clears on exit.
                    r_lastOwner <= r_owner;
                    r_locked    <= w_ownerLock;
                    if (!w_ownerLock) begin
                        grant0 <= 1'b0;
                        grant1 <= 1'b0;
                        CS     <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares one SD_CMD command engine and one SD_RP response engine between two requesters.
- Typical requesters are the SD init sequencer (port 0) and the block-read controller (port 1).
- Arbitrates round-robin and sequences each transaction: command, then response.
- Drives card CS and returns the R1 byte to the granted requester, with a response timeout.

Parameters:
- TIMEOUT_CYCLES, 4096: clk cycles allowed in RP_WAIT before the transaction aborts.
- CNT_W, 13: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request level; held high until done seen while granted.
- index0 / index1  in  6  command index; sampled at grant.
- argument0 / argument1  in  32  command argument; sampled at grant.
- lock0 / lock1  in  1  sampled at DONE; keep grant and CS low for a follow-on command (CMD55+ACMD41).
- grant0 / grant1  out  1  one-hot owner indication.
- done  out  1  one-cycle pulse to the current owner.
- response  out  8  R1 byte latched at DONE; 8'hFF on timeout.
- timeout  out  1  valid with done; 1 means no response arrived.
- cmdIndex  out  6  to SD_CMD index.
- cmdArgument  out  32  to SD_CMD argument.
- cmdStart  out  1  to SD_CMD isStart.
- cmdBusy  in  1  from SD_CMD isBusy.
- cmdFinish  in  1  from SD_CMD isFinish.
- rpStart  out  1  to SD_RP isStart.
- rpBusy  in  1  from SD_RP isBusy.
- rpFinish  in  1  from SD_RP isFinish.
- rpResponse  in  8  from SD_RP response.
- CS  out  1  card chip select, active low.

Behaviour:
- Reset values, applied one edge after reset goes high, including mid-transaction:
  - state=IDLE.
  - CS=1.
  - grant0=grant1=0, done=0, timeout=0.
  - cmdStart=0, rpStart=0.
  - response=8'hFF.
  - cmdIndex=0, cmdArgument=0.
  - lastOwner=1, so req0 wins the first tie.
  - locked=0.
- Engine handshake:
  - SD engines hold isFinish high until their isStart drops.
  - The arbiter keeps a start level high until the matching finish is sampled high on clk, then drops it on the next edge.
- IDLE:
  - If locked, serve only the locked owner; the other request waits.
  - Otherwise, if exactly one req is high, grant it.
  - If both are high, grant the port that is not lastOwner.
  - On grant: latch index/argument into cmdIndex/cmdArgument, assert grantN, CS=0, go to LOAD. The grant becomes visible one edge after req.
- LOAD: wait for cmdBusy=0, then go to CMD_START.
- CMD_START: cmdStart=1, go to CMD_WAIT.
- CMD_WAIT: on cmdFinish=1, set cmdStart=0 and go to RP_START.
- RP_START: wait for rpBusy=0, then rpStart=1, clear the timeout counter, go to RP_WAIT.
- RP_WAIT: the counter increments each cycle.
  - On rpFinish=1: response=rpResponse, timeout=0.
  - Else when counter == TIMEOUT_CYCLES-1: response=8'hFF, timeout=1.
  - Either way: rpStart=0, go to DONE.
- DONE (one cycle):
  - done=1, lastOwner=owner, locked=lockN of the owner.
  - If not locked: drop grant, CS=1.
  - Go to IDLE; done clears on the next edge.
- Requests that rise during DONE are arbitrated in the following IDLE cycle, never in DONE.
- If the owner drops req while granted, the transaction still completes; done is still pulsed.
- If the locked owner holds req low in IDLE, it keeps grant and CS=0 indefinitely. Releasing means a transaction with lockN=0, or reset.
- response/timeout hold their values until the next DONE.
- Exactly one of grant0/grant1 is high whenever state≠IDLE.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding (IDLE, LOAD, CMD_START, CMD_WAIT, RP_START, RP_WAIT, DONE) as 3-bit constants;
  - R1_NONE=8'hFF;
  - SD command index constants (CMD0, CMD8, CMD17, CMD55, ACMD41).
- One sub-module, sd_rr_pick: combinational 2-way round-robin picker with inputs req, lastOwner and locked, output a one-hot pick.
- The FSM and timeout counter stay in the top module.

Test Plan:
- req0 only, index0=0, argument0=0; engine returns 8'h01 → grant0 one edge after req0, cmdIndex=0, CS low, done pulse with response=8'h01, timeout=0, CS=1 after DONE.
- req0 and req1 rise on the same cycle after reset → port 0 served first; port 1 granted in the IDLE cycle after port 0's DONE; with both still requesting afterwards, service alternates 0,1,0.
- req1 with lock1=1, CMD55, then CMD41 while req0 is pending → CS stays low, port 1 served twice consecutively; req0 granted only after the lock1=0 transaction.
- rpFinish never asserted → done exactly TIMEOUT_CYCLES cycles after rpStart rises, response=8'hFF, timeout=1.
- cmdBusy held high 50 cycles at grant → cmdStart not asserted until cmdBusy falls; no rpStart before cmdFinish.
- reset asserted during CMD_WAIT → next edge cmdStart=0, grants 0, CS=1, state IDLE; a subsequent req1 is granted normally.
